// File: rtl/cpu_seq_fsm.sv
// Purpose : Hack CPU control FSM sequencing fetch/read/write/latch over a multi-beat SPI master.
// Latency : one cycle from beat pending to spiStart_o; 4 cycles minimum per A-instruction (BEATS=1).
// Backpr. : each beat waits on spiDone_i; halt_i is taken only at the LATCH boundary.
// Option  : define CPU_FSM_TIMEOUT_EN to enable the SPI watchdog (ERROR state, sticky err_o).
module cpu_seq_fsm #(
  parameter int BEATS          = 1,
  parameter int BEAT_W         = $clog2(BEATS > 1 ? BEATS : 2),
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              cab_i,
  input  logic              readMem_i,
  input  logic              latchMem_i,
  input  logic              halt_i,
  input  logic              spiDone_i,
  output logic              spiStart_o,
  output logic [BEAT_W-1:0] beat_o,
  output logic              rwb_o,
  output logic              selSPIAddress_o,
  output logic              selSPIDest_o,
  output logic              enLatch_o,
  output logic              halted_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  instrCount_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    FETCH_INSTRUCTION = 3'd0,
    FETCH_MEMORY      = 3'd1,
    SAVE_MEMORY       = 3'd2,
    LATCH             = 3'd3,
    HALTED            = 3'd4,
    ERROR             = 3'd5
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t             state;
  state_t             next_access;
  logic [BEAT_W-1:0]  beat;
  logic               pending;      // a beat must be started next cycle
  logic               outstanding;  // a started beat awaits spiDone_i
  logic               start;
  logic [CNT_W-1:0]   count;
  logic               done_ok;
  logic               last_beat;
  logic               timeout;

  // A done only counts for a beat we actually started, and never in the start cycle itself
  assign done_ok   = spiDone_i & outstanding & ~start;
  assign last_beat = (beat == LAST_BEAT);

`ifdef CPU_FSM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  assign timeout = outstanding & ~done_ok & (wd >= WD_W'(TIMEOUT_CYCLES));
  assign err_o   = (state == ERROR);

  // Watchdog: cycles elapsed since the last spiStart_o of the outstanding beat
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wd <= '0;
    end else if (start) begin
      wd <= WD_W'(1);
    end else if (outstanding && (wd < WD_W'(TIMEOUT_CYCLES))) begin
      wd <= wd + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout    = 1'b0;
  assign err_o      = 1'b0;
`endif

  // Where the final beat of the current access leads, using decode inputs of that cycle
  always_comb begin
    next_access = LATCH;
    case (state)
      FETCH_INSTRUCTION: begin
        if (cab_i && readMem_i)       next_access = FETCH_MEMORY;
        else if (cab_i && latchMem_i) next_access = SAVE_MEMORY;
        else                          next_access = LATCH;
      end
      FETCH_MEMORY: next_access = latchMem_i ? SAVE_MEMORY : LATCH;
      default:      next_access = LATCH;
    endcase
  end

  // Main sequencer: beat handshake, state transitions and retired-instruction count
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= FETCH_INSTRUCTION;
      beat        <= '0;
      pending     <= 1'b1;
      outstanding <= 1'b0;
      start       <= 1'b0;
      count       <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        FETCH_INSTRUCTION, FETCH_MEMORY, SAVE_MEMORY: begin
          if (timeout) begin
            state       <= ERROR;
            beat        <= '0;
            pending     <= 1'b0;
            outstanding <= 1'b0;
          end else if (pending) begin
            start       <= 1'b1;
            pending     <= 1'b0;
            outstanding <= 1'b1;
          end else if (done_ok) begin
            outstanding <= 1'b0;
            pending     <= 1'b1;
            if (last_beat) begin
              beat  <= '0;
              state <= next_access;
            end else begin
              beat  <= beat + 1'b1;
            end
          end
        end
        LATCH: begin
          count   <= count + 1'b1;
          pending <= 1'b1;
          state   <= halt_i ? HALTED : FETCH_INSTRUCTION;
        end
        HALTED: begin
          if (!halt_i) begin
            state   <= FETCH_INSTRUCTION;
            pending <= 1'b1;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state       <= FETCH_INSTRUCTION;
          beat        <= '0;
          pending     <= 1'b1;
          outstanding <= 1'b0;
        end
      endcase
    end
  end

  // SPI steering decoded from the registered state
  always_comb begin
    rwb_o           = 1'b1;
    selSPIAddress_o = 1'b0;
    selSPIDest_o    = 1'b0;
    case (state)
      FETCH_MEMORY: begin
        selSPIAddress_o = 1'b1;
        selSPIDest_o    = 1'b1;
      end
      SAVE_MEMORY: begin
        rwb_o           = 1'b0;
        selSPIAddress_o = 1'b1;
        selSPIDest_o    = 1'b1;
      end
      default: begin
        rwb_o           = 1'b1;
        selSPIAddress_o = 1'b0;
        selSPIDest_o    = 1'b0;
      end
    endcase
  end

  assign spiStart_o   = start;
  assign beat_o       = beat;
  assign enLatch_o    = (state == LATCH);
  assign halted_o     = (state == HALTED);
  assign instrCount_o = count;
  assign state_o      = state;

endmodule

// File: tb/tb_cpu_seq_fsm.sv
// Bench for cpu_seq_fsm: u0 is BEATS=1, u1 is BEATS=2, both CNT_W=4, TIMEOUT_CYCLES=8.
// Directed scenarios with hand-computed expectations; inputs change 1 time unit after posedge.
module tb_cpu_seq_fsm;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic cab = 1'b0, rd = 1'b0, wr = 1'b0, halt = 1'b0;
  logic done0 = 1'b0, done1 = 1'b0;

  logic       sp0, rwb0, addr0, dest0, en0, hlt0, err0;
  logic [0:0] beat0;
  logic [3:0] cnt0;
  logic [2:0] st0;
  logic       sp1, rwb1, addr1, dest1, en1, hlt1, err1;
  logic [0:0] beat1;
  logic [3:0] cnt1;
  logic [2:0] st1;

  int vecs = 0;
  int errs = 0;
  int starts1;

  always #5 clk = ~clk;

  cpu_seq_fsm #(.BEATS(1), .CNT_W(4), .TIMEOUT_CYCLES(8)) u0 (
    .clk(clk), .resetb(resetb), .cab_i(cab), .readMem_i(rd), .latchMem_i(wr),
    .halt_i(halt), .spiDone_i(done0), .spiStart_o(sp0), .beat_o(beat0),
    .rwb_o(rwb0), .selSPIAddress_o(addr0), .selSPIDest_o(dest0),
    .enLatch_o(en0), .halted_o(hlt0), .err_o(err0), .instrCount_o(cnt0),
    .state_o(st0));

  cpu_seq_fsm #(.BEATS(2), .CNT_W(4), .TIMEOUT_CYCLES(8)) u1 (
    .clk(clk), .resetb(resetb), .cab_i(cab), .readMem_i(rd), .latchMem_i(wr),
    .halt_i(halt), .spiDone_i(done1), .spiStart_o(sp1), .beat_o(beat1),
    .rwb_o(rwb1), .selSPIAddress_o(addr1), .selSPIDest_o(dest1),
    .enLatch_o(en1), .halted_o(hlt1), .err_o(err1), .instrCount_o(cnt1),
    .state_o(st1));

  // Count spiStart_o pulses of u1
  always @(posedge clk or negedge resetb) begin
    if (!resetb) starts1 <= 0;
    else if (sp1) starts1 <= starts1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    tick();
    tick();
    resetb = 1'b1;
  endtask

  task automatic wait_start(input int which);
    int n = 0;
    while (!((which == 0) ? sp0 : sp1) && n < 20) begin
      tick();
      n++;
    end
    check("start_seen", (which == 0) ? sp0 : sp1, 1'b1);
  endtask

  // One u1 beat: wait for its start, check steering, answer done one cycle later
  task automatic beat_u1(input string tag, input logic [2:0] est, input logic eb,
                         input logic erwb, input logic eaddr, input logic edest);
    wait_start(1);
    check({tag, "_state"}, st1, est);
    check({tag, "_beat"}, beat1, eb);
    check({tag, "_rwb"}, rwb1, erwb);
    check({tag, "_addr"}, addr1, eaddr);
    check({tag, "_dest"}, dest1, edest);
    tick();
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
  endtask

  // One u0 A-instruction: start, done next cycle, LATCH, back to fetch
  task automatic instr_u0();
    wait_start(0);
    tick();
    done0 = 1'b1;
    tick();
    done0 = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s;
    // ---------------- reset values ----------------
    resetb = 1'b0;
    tick();
    tick();
    check("rst_state", st1, 3'd0);
    check("rst_start", sp1, 1'b0);
    check("rst_beat", beat1, 1'b0);
    check("rst_enlatch", en1, 1'b0);
    check("rst_halted", hlt1, 1'b0);
    check("rst_err", err1, 1'b0);
    check("rst_count", cnt1, 4'd0);
    check("rst_rwb", rwb1, 1'b1);

    // ---------------- 1: BEATS=1 A-instruction, 4-cycle period ----------------
    resetb = 1'b1;
    tick();
    check("t1_start", sp0, 1'b1);
    check("t1_state0", st0, 3'd0);
    check("t1_rwb", rwb0, 1'b1);
    check("t1_addr", addr0, 1'b0);
    tick();
    check("t1_start_pulse", sp0, 1'b0);
    done0 = 1'b1;
    tick();
    done0 = 1'b0;
    check("t1_latch", st0, 3'd3);
    check("t1_enlatch", en0, 1'b1);
    check("t1_cnt_in_latch", cnt0, 4'd0);
    tick();
    check("t1_back_fetch", st0, 3'd0);
    check("t1_enlatch_off", en0, 1'b0);
    check("t1_cnt", cnt0, 4'd1);
    check("t1_no_start_yet", sp0, 1'b0);
    tick();
    check("t1_next_start", sp0, 1'b1);

    // ---------------- 2: BEATS=2 C-instr read+write ----------------
    cab = 1'b1; rd = 1'b1; wr = 1'b1;
    do_reset();
    beat_u1("t2_fi0", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    beat_u1("t2_fi1", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    beat_u1("t2_fm0", 3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    beat_u1("t2_fm1", 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    beat_u1("t2_sm0", 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    beat_u1("t2_sm1", 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t2_latch", st1, 3'd3);
    check("t2_enlatch", en1, 1'b1);
    check("t2_beat_exit", beat1, 1'b0);
    check("t2_starts", starts1, 6);
    tick();
    check("t2_fetch", st1, 3'd0);
    check("t2_cnt", cnt1, 4'd1);

    // ---------------- 3: halt during FETCH_MEMORY ----------------
    cab = 1'b1; rd = 1'b1; wr = 1'b0;
    beat_u1("t3_fi0", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    beat_u1("t3_fi1", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_start(1);
    check("t3_fm_state", st1, 3'd1);
    halt = 1'b1;
    tick();
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    beat_u1("t3_fm1", 3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t3_latch", st1, 3'd3);
    tick();
    check("t3_halted_state", st1, 3'd4);
    check("t3_halted", hlt1, 1'b1);
    check("t3_cnt", cnt1, 4'd2);
    s = starts1;
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    tick();
    tick();
    check("t3_stray_done_state", st1, 3'd4);
    check("t3_no_start", sp1, 1'b0);
    check("t3_no_starts", starts1, s);
    halt = 1'b0;
    tick();
    check("t3_resume", st1, 3'd0);
    check("t3_halted_off", hlt1, 1'b0);

    // ---------------- 6: reset mid-beat of SAVE_MEMORY ----------------
    cab = 1'b1; rd = 1'b0; wr = 1'b1;
    beat_u1("t6_fi0", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    beat_u1("t6_fi1", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    beat_u1("t6_sm0", 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_start(1);
    check("t6_sm1_beat", beat1, 1'b1);
    tick();
    resetb = 1'b0;
    #1;
    check("t6_rst_state", st1, 3'd0);
    check("t6_rst_beat", beat1, 1'b0);
    check("t6_rst_rwb", rwb1, 1'b1);
    check("t6_rst_addr", addr1, 1'b0);
    check("t6_rst_cnt", cnt1, 4'd0);
    check("t6_rst_start", sp1, 1'b0);
    tick();
    check("t6_hold_start", sp1, 1'b0);
    resetb = 1'b1;
    tick();
    check("t6_first_start", sp1, 1'b1);
    check("t6_first_state", st1, 3'd0);

    // ---------------- 4: counter wrap with CNT_W=4 ----------------
    cab = 1'b0; rd = 1'b0; wr = 1'b0;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      instr_u0();
      check($sformatf("t4_cnt_%0d", i), cnt0, i % 16);
    end

    // ---------------- 5: no spiDone_i ----------------
    do_reset();
    for (int i = 0; i < 20; i++) tick();
`ifdef CPU_FSM_TIMEOUT_EN
    check("t5_error_state", st1, 3'd5);
    check("t5_err", err1, 1'b1);
    halt = 1'b1;
    done1 = 1'b1;
    tick();
    tick();
    halt = 1'b0;
    done1 = 1'b0;
    tick();
    check("t5_error_sticky", st1, 3'd5);
    check("t5_err_sticky", err1, 1'b1);
`else
    check("t5_wait_state", st1, 3'd0);
    check("t5_no_err", err1, 1'b0);
    check("t5_single_start", starts1, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
